// File: rtl/fas_pkg.sv
// Shared definitions for the FAS frame sequencer: sample width, default
// frame geometry and the sequencer state encoding.
package fas_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int FRAME_LEN_DEF  = 16;
    localparam int NUM_FRAMES_DEF = 64;

    typedef logic [1:0] fas_state_t;

    localparam fas_state_t ST_IDLE   = 2'd0;
    localparam fas_state_t ST_START  = 2'd1;
    localparam fas_state_t ST_WAIT   = 2'd2;
    localparam fas_state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/fas_pingpong_buf.sv
// Two-bank sample buffer with write pointer, per-bank full flags and overflow
// detection. Optional saturating drop counter under FAS_CTRL_OVF_CNT_EN.
module fas_pingpong_buf
    import fas_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en_i,
    input  logic [SAMPLE_W-1:0]           wr_data_i,
    input  logic                          free_i,
    input  logic                          rd_bank_i,
    output logic [SAMPLE_W*FRAME_LEN-1:0] rd_frame_o,
    output logic [1:0]                    bank_full_o,
    output logic                          ovf_o,
    output logic [7:0]                    ovf_cnt_o
);

    localparam int PTR_W = $clog2(FRAME_LEN);

    logic                wr_bank_q, wr_bank_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]          full_q, full_d;
    logic                ovf_q, ovf_d;
    logic [SAMPLE_W-1:0] mem_q [2][FRAME_LEN];
    logic                wr_blocked;
    logic                do_write;
    logic                drop;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        // A bank freed this cycle accepts the arriving sample.
        wr_blocked = full_q[wr_bank_q] && !(free_i && (rd_bank_i == wr_bank_q));
        do_write   = wr_en_i && !wr_blocked;
        drop       = wr_en_i && wr_blocked;
        full_d     = full_q;
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        ovf_d      = ovf_q | drop;
        if (free_i) begin
            full_d[rd_bank_i] = 1'b0;
        end
        if (do_write) begin
            if (wr_ptr_q == PTR_W'(FRAME_LEN - 1)) begin
                wr_ptr_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    // NOTE: the banks are reset so frame_d reads zero after reset; this costs a
    // reset net on every storage bit and keeps the array out of RAM macros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < FRAME_LEN; k++) begin
                    mem_q[b][k] <= '0;
                end
            end
        end else if (do_write) begin
            mem_q[wr_bank_q][wr_ptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        rd_frame_o = '0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            rd_frame_o[k*SAMPLE_W +: SAMPLE_W] = mem_q[rd_bank_i][k];
        end
    end

    assign bank_full_o = full_q;
    assign ovf_o       = ovf_q;

`ifdef FAS_CTRL_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

endmodule

// File: rtl/fas_frame_ctrl.sv
// FAS frame sequencer between FIR and FFT: ping-pong framing, FFT launch FSM
// and frame counter. FAS_CTRL_OVF_CNT_EN enables the dropped-sample counter.
module fas_frame_ctrl
    import fas_pkg::*;
#(
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fir_valid,
    input  logic [SAMPLE_W-1:0]           fir_d,
    input  logic                          fft_valid,
    output logic                          fft_start,
    output logic [SAMPLE_W*FRAME_LEN-1:0] frame_d,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          done,
    output logic                          ovf,
    output logic [7:0]                    ovf_cnt
);

    localparam int IDX_W = $clog2(NUM_FRAMES);

    fas_state_t       state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             free;
    logic [1:0]       bank_full;

    fas_pingpong_buf #(
        .FRAME_LEN (FRAME_LEN)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst),
        .wr_en_i     (fir_valid && !done),
        .wr_data_i   (fir_d),
        .free_i      (free),
        .rd_bank_i   (rd_bank_q),
        .rd_frame_o  (frame_d),
        .bank_full_o (bank_full),
        .ovf_o       (ovf),
        .ovf_cnt_o   (ovf_cnt)
    );

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        idx_d     = idx_q;
        free      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bank_full[rd_bank_q]) begin
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (fft_valid) begin
                    free      = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    // The last frame keeps its index; the sequencer parks in FINISH.
                    if (idx_q == IDX_W'(NUM_FRAMES - 1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
        end
    end

    assign fft_start = (state_q == ST_START);
    assign done      = (state_q == ST_FINISH);
    assign frame_idx = idx_q;

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Scoreboard bench for fas_frame_ctrl: expected frames are queued as samples
// are driven and compared when the DUT pulses fft_start.
module tb_fas_frame_ctrl;

    localparam int FL = 16;
    localparam int NF = 64;
    localparam int FW = 16 * FL;
`ifdef FAS_CTRL_OVF_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          fir_valid = 1'b0;
    logic [15:0]   fir_d     = '0;
    logic          fft_valid = 1'b0;
    logic          fft_start;
    logic [FW-1:0] frame_d;
    logic [5:0]    frame_idx;
    logic          done;
    logic          ovf;
    logic [7:0]    ovf_cnt;

    typedef struct {
        logic [FW-1:0] frame;
        logic [5:0]    idx;
    } exp_t;

    exp_t          exp_q[$];
    int            compared       = 0;
    int            mismatched     = 0;
    int            cyc            = 0;
    int            launches       = 0;
    int            last_start_cyc = -1;
    int            last_cyc       = 0;
    int            ack_cyc        = 0;
    logic          in_flight      = 1'b0;
    logic          prev_start     = 1'b0;
    logic [FW-1:0] cur_frame      = '0;

    fas_frame_ctrl #(.FRAME_LEN(FL), .NUM_FRAMES(NF)) dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .fft_valid (fft_valid),
        .fft_start (fft_start),
        .frame_d   (frame_d),
        .frame_idx (frame_idx),
        .done      (done),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop on each launch, and hold the launched frame until acknowledged.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (in_flight) begin
                compared++;
                if (frame_d !== cur_frame) begin
                    mismatched++;
                    $display("FAIL frame_hold: frame_d=%h expected %h", frame_d, cur_frame);
                end
                if (fft_valid) in_flight = 1'b0;
            end
            if (fft_start) begin
                compared++;
                if (prev_start) begin
                    mismatched++;
                    $display("FAIL start_width: fft_start high on consecutive cycles, expected one-cycle pulse");
                end else if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_launch: fft_start with frame_idx=%0d, expected no launch", frame_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (frame_d !== e.frame || frame_idx !== e.idx) begin
                        mismatched++;
                        $display("FAIL launch_data: frame_d=%h idx=%0d, expected frame_d=%h idx=%0d",
                                 frame_d, frame_idx, e.frame, e.idx);
                    end
                    cur_frame = e.frame;
                end
                in_flight      = 1'b1;
                launches++;
                last_start_cyc = cyc;
            end
            prev_start = fft_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    function automatic logic [FW-1:0] mk_frame(input int base);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < FL; k++) f[16*k +: 16] = 16'(base + k);
        return f;
    endfunction

    task automatic push(input int base, input int idx);
        exp_t e;
        e.frame = mk_frame(base);
        e.idx   = 6'(idx);
        exp_q.push_back(e);
    endtask

    task automatic stream(input int base, input int n, input int ack_at);
        for (int i = 0; i < n; i++) begin
            fir_valid = 1'b1;
            fir_d     = 16'(base + i);
            fft_valid = (i == ack_at);
            @(posedge clk);
            #1;
            if (i == ack_at) ack_cyc = cyc;
        end
        fir_valid = 1'b0;
        fft_valid = 1'b0;
        last_cyc  = cyc;
    endtask

    task automatic ack();
        fft_valid = 1'b1;
        @(posedge clk);
        #1;
        ack_cyc   = cyc;
        fft_valid = 1'b0;
    endtask

    task automatic wait_launch(input int n);
        for (int k = 0; k < 40 && launches < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared += 6;
        if (fft_start !== 1'b0) begin mismatched++; $display("FAIL rst_start: %b expected 0", fft_start); end
        if (frame_d !== '0)     begin mismatched++; $display("FAIL rst_frame: %h expected 0", frame_d); end
        if (frame_idx !== 6'd0) begin mismatched++; $display("FAIL rst_idx: %0d expected 0", frame_idx); end
        if (done !== 1'b0)      begin mismatched++; $display("FAIL rst_done: %b expected 0", done); end
        if (ovf !== 1'b0)       begin mismatched++; $display("FAIL rst_ovf: %b expected 0", ovf); end
        if (ovf_cnt !== 8'd0)   begin mismatched++; $display("FAIL rst_ovf_cnt: %0d expected 0", ovf_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_first_frame();
        push(0, 0);
        stream(0, FL, -1);
        wait_launch(1);
        compared++;
        if (launches != 1 || last_start_cyc != last_cyc + 1) begin
            mismatched++;
            $display("FAIL first_launch: launches=%0d at cyc %0d, expected 1 at cyc %0d", launches, last_start_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_ack_pending();
        push(16, 1);
        stream(16, FL, -1);
        ack();
        wait_launch(2);
        compared += 2;
        if (launches != 2 || last_start_cyc != ack_cyc + 1) begin
            mismatched++;
            $display("FAIL pending_launch: launches=%0d at cyc %0d, expected 2 at cyc %0d", launches, last_start_cyc, ack_cyc + 1);
        end
        if (ovf !== 1'b0) begin mismatched++; $display("FAIL pending_ovf: %b expected 0", ovf); end
    endtask

    task automatic test_ack_midstream();
        push(32, 2);
        stream(32, FL, 5);
        wait_launch(3);
        compared++;
        if (launches != 3 || last_start_cyc != last_cyc + 1) begin
            mismatched++;
            $display("FAIL midstream_launch: launches=%0d at cyc %0d, expected 3 at cyc %0d", launches, last_start_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_simultaneous();
        push(48, 3);
        stream(48, FL, -1);
        stream(64, 1, 0);
        wait_launch(4);
        compared++;
        if (launches != 4 || last_start_cyc != ack_cyc + 1) begin
            mismatched++;
            $display("FAIL simul_launch: launches=%0d at cyc %0d, expected 4 at cyc %0d", launches, last_start_cyc, ack_cyc + 1);
        end
        push(64, 4);
        stream(65, FL - 1, -1);
        compared += 3;
        if (ovf !== 1'b0)     begin mismatched++; $display("FAIL simul_ovf: %b expected 0", ovf); end
        if (ovf_cnt !== 8'd0) begin mismatched++; $display("FAIL simul_ovf_cnt: %0d expected 0", ovf_cnt); end
        if (launches != 4)    begin mismatched++; $display("FAIL simul_hold: launches=%0d expected 4", launches); end
    endtask

    task automatic test_overflow();
        stream(80, FL, -1);
        compared += 3;
        if (ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: %b expected 1", ovf); end
        if (ovf_cnt !== 8'(CNT_ON * 16)) begin
            mismatched++; $display("FAIL ovf_cnt16: %0d expected %0d", ovf_cnt, CNT_ON * 16);
        end
        if (launches != 4) begin mismatched++; $display("FAIL ovf_launch: launches=%0d expected 4", launches); end
        stream(2000, 240, -1);
        compared++;
        if (ovf_cnt !== 8'(CNT_ON * 255)) begin
            mismatched++; $display("FAIL ovf_cnt_sat: %0d expected %0d", ovf_cnt, CNT_ON * 255);
        end
        ack();
        wait_launch(5);
        compared++;
        if (launches != 5 || last_start_cyc != ack_cyc + 1) begin
            mismatched++;
            $display("FAIL ovf_relaunch: launches=%0d at cyc %0d, expected 5 at cyc %0d", launches, last_start_cyc, ack_cyc + 1);
        end
        ack();
    endtask

    task automatic test_done();
        for (int f = 5; f < NF; f++) begin
            push(16 * f, f);
            stream(16 * f, FL, -1);
            wait_launch(f + 1);
            compared++;
            if (launches != f + 1 || last_start_cyc != last_cyc + 1) begin
                mismatched++;
                $display("FAIL frame_launch: launches=%0d at cyc %0d, expected %0d at cyc %0d",
                         launches, last_start_cyc, f + 1, last_cyc + 1);
            end
            if (f < NF - 1) ack();
        end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL done_early: %b expected 0", done); end
        ack();
        compared += 2;
        if (done !== 1'b1)       begin mismatched++; $display("FAIL done_rise: %b expected 1", done); end
        if (frame_idx !== 6'd63) begin mismatched++; $display("FAIL done_idx: %0d expected 63", frame_idx); end
        stream(3000, 20, 3);
        repeat (3) begin @(posedge clk); #1; end
        compared += 4;
        if (launches != NF) begin mismatched++; $display("FAIL finish_launch: launches=%0d expected %0d", launches, NF); end
        if (done !== 1'b1)  begin mismatched++; $display("FAIL finish_done: %b expected 1", done); end
        if (ovf_cnt !== 8'(CNT_ON * 255)) begin
            mismatched++; $display("FAIL finish_ovf_cnt: %0d expected %0d", ovf_cnt, CNT_ON * 255);
        end
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL finish_queue: %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midwait();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(400, 0);
        stream(400, FL, -1);
        wait_launch(NF + 1);
        stream(600, 8, -1);
        rst       = 1'b0;
        in_flight = 1'b0;
        #2;
        compared += 6;
        if (fft_start !== 1'b0) begin mismatched++; $display("FAIL mid_rst_start: %b expected 0", fft_start); end
        if (frame_d !== '0)     begin mismatched++; $display("FAIL mid_rst_frame: %h expected 0", frame_d); end
        if (frame_idx !== 6'd0) begin mismatched++; $display("FAIL mid_rst_idx: %0d expected 0", frame_idx); end
        if (done !== 1'b0)      begin mismatched++; $display("FAIL mid_rst_done: %b expected 0", done); end
        if (ovf !== 1'b0)       begin mismatched++; $display("FAIL mid_rst_ovf: %b expected 0", ovf); end
        if (ovf_cnt !== 8'd0)   begin mismatched++; $display("FAIL mid_rst_ovf_cnt: %0d expected 0", ovf_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(700, 0);
        stream(700, FL, -1);
        wait_launch(NF + 2);
        compared += 2;
        if (launches != NF + 2 || last_start_cyc != last_cyc + 1) begin
            mismatched++;
            $display("FAIL post_rst_launch: launches=%0d at cyc %0d, expected %0d at cyc %0d",
                     launches, last_start_cyc, NF + 2, last_cyc + 1);
        end
        if (exp_q.size() != 0) begin mismatched++; $display("FAIL post_rst_queue: %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_ack_pending();
        test_ack_midstream();
        test_simultaneous();
        test_overflow();
        test_done();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
